uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo -- UART transmitter with a transmit FIFO in front of it.
//
// Bytes written with wr_en are queued in a FIFO_DEPTH-entry FIFO. A framing FSM
// pops one byte at a time and serialises it as start / data / [parity] / stop,
// using a copy of uart_config latched when the frame begins. A line break can
// be requested with break_req; it is only started between frames.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz (bit period = CLK_FREQ / baud)
//   FIFO_DEPTH  FIFO entries, power of two, >= 2
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   wr_en        write strobe (dropped and flagged via overflow when full)
//   wr_data      byte to enqueue
//   uart_config  baud_rate / stop_bits / data_bits / parity / bit_order
//   break_req    request a line break (tx held low while high)
//   cts_n        clear-to-send, active low (only with UART_TX_CTS_EN)
//   tx           serial output, idle high
//   busy         framing FSM is not idle
//   full, empty  FIFO status
//   level        FIFO occupancy
//   overflow     one-cycle pulse after a write was attempted while full
//
// Build option
//   UART_TX_CTS_EN  adds the cts_n port; new frames start only while cts_n==0.
// -----------------------------------------------------------------------------

package uart_tx_pkg;
    // baud_rate codes; any other code runs at 9600
    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;
    // stop_bits codes; code 3 behaves as one stop bit
    localparam logic [1:0] STOP_1      = 2'd0;
    localparam logic [1:0] STOP_1_5    = 2'd1;
    localparam logic [1:0] STOP_2      = 2'd2;
    // data_bits codes: number of bits sent is code + 5
    localparam logic [1:0] DATA_5      = 2'd0;
    localparam logic [1:0] DATA_6      = 2'd1;
    localparam logic [1:0] DATA_7      = 2'd2;
    localparam logic [1:0] DATA_8      = 2'd3;
    // parity codes; code 3 sends no parity bit
    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;
    // bit_order codes
    localparam logic       LSB_FIRST   = 1'b0;
    localparam logic       MSB_FIRST   = 1'b1;

    typedef struct packed {
        logic [2:0] baud_rate;
        logic [1:0] stop_bits;
        logic [1:0] data_bits;
        logic [1:0] parity;
        logic       bit_order;
    } uart_config_t;
endpackage

module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 1843200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  uart_config_t                  uart_config,
    input  logic                          break_req,
`ifdef UART_TX_CTS_EN
    input  logic                          cts_n,
`endif
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int LW       = AW + 1;
    localparam int P_9600   = CLK_FREQ / 9600;
    localparam int P_19200  = CLK_FREQ / 19200;
    localparam int P_38400  = CLK_FREQ / 38400;
    localparam int P_57600  = CLK_FREQ / 57600;
    localparam int P_115200 = CLK_FREQ / 115200;
    // The longest interval ever counted is two stop bits at 9600 baud.
    localparam int CNT_W    = $clog2(2 * P_9600 + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    // ---------------------------------------------------------------- FIFO --
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          full_c, empty_c, push, pop;
    logic [7:0]    head_c;

    assign full_c  = (level_q == LW'(FIFO_DEPTH));
    assign empty_c = (level_q == '0);
    // A write while full is lost even if the FSM pops in the same cycle.
    assign push    = wr_en && !full_c;
    assign head_c  = fifo_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q + LW'(push) - LW'(pop);
        overflow_d = wr_en && full_c;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wr_data;
        end
    end

    // ----------------------------------------------------------- framing --
    state_t        state_q, state_d;
    logic          tx_q, tx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    data_q, data_d;
    uart_config_t  cfg_q, cfg_d;

    logic             cts_ok;
    logic [CNT_W-1:0] period_c, stop_len_c;
    logic             bit_end, stop_end;
    logic [2:0]       last_idx_c;
    logic [7:0]       data_mask_c;
    logic             parity_en_c, parity_bit_c;

`ifdef UART_TX_CTS_EN
    assign cts_ok = ~cts_n;
`else
    assign cts_ok = 1'b1;
`endif

    // Bit timing always follows the configuration latched for this frame.
    always_comb begin
        case (cfg_q.baud_rate)
            BAUD_19200:  period_c = CNT_W'(P_19200);
            BAUD_38400:  period_c = CNT_W'(P_38400);
            BAUD_57600:  period_c = CNT_W'(P_57600);
            BAUD_115200: period_c = CNT_W'(P_115200);
            default:     period_c = CNT_W'(P_9600);
        endcase
        case (cfg_q.stop_bits)
            // 3*period/2 truncated equals period + floor(period/2)
            STOP_1_5: stop_len_c = period_c + (period_c >> 1);
            STOP_2:   stop_len_c = period_c << 1;
            default:  stop_len_c = period_c;
        endcase
    end

    assign bit_end      = (cnt_q == period_c - CNT_W'(1));
    assign stop_end     = (cnt_q == stop_len_c - CNT_W'(1));
    assign last_idx_c   = 3'(cfg_q.data_bits) + 3'd4;
    // Only the bits actually transmitted contribute to parity.
    assign data_mask_c  = 8'hFF >> (2'd3 - cfg_q.data_bits);
    assign parity_en_c  = (cfg_q.parity == PARITY_EVEN) || (cfg_q.parity == PARITY_ODD);
    assign parity_bit_c = (^(data_q & data_mask_c)) ^ (cfg_q.parity == PARITY_ODD);

    // idx counts transmitted bits; MSB-first walks down from the top data bit.
    function automatic logic pick_bit(input logic [7:0] d, input logic msb_first,
                                      input logic [2:0] last, input logic [2:0] idx);
        return msb_first ? d[last - idx] : d[idx];
    endfunction

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        cfg_d     = cfg_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (break_req) begin
                    state_d = BREAK;
                    tx_d    = 1'b0;
                    cfg_d   = uart_config;
                end else if (!empty_c && cts_ok) begin
                    pop     = 1'b1;
                    data_d  = head_c;
                    cfg_d   = uart_config;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = pick_bit(data_q, cfg_q.bit_order, last_idx_c, 3'd0);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == last_idx_c) begin
                        if (parity_en_c) begin
                            state_d = PARITY;
                            tx_d    = parity_bit_c;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = pick_bit(data_q, cfg_q.bit_order, last_idx_c,
                                             bit_idx_q + 3'd1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (stop_end) begin
                    cnt_d = '0;
                    // Chain straight into the next frame when one is waiting;
                    // a pending break waits for IDLE.
                    if (!empty_c && !break_req && cts_ok) begin
                        pop     = 1'b1;
                        data_d  = head_c;
                        cfg_d   = uart_config;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            BREAK: begin
                // tx_q doubles as the phase flag: low = holding the break,
                // high = one bit period of mark before returning to IDLE.
                if (break_req) begin
                    tx_d  = 1'b0;
                    cnt_d = '0;
                end else if (!tx_q) begin
                    tx_d  = 1'b1;
                    cnt_d = '0;
                end else if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            cfg_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            cfg_q      <= cfg_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE);
    assign full     = full_c;
    assign empty    = empty_c;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule
